// File: rtl/updown_counter_gen_if.sv
// Control/status bundle of updown_counter_gen: button pulses, UART command
// strobe, preset load and the display-facing count/status outputs.
interface updown_counter_gen_if #(
  parameter int COUNT_W = 14
);
  logic               btn_mode;
  logic               btn_run_stop;
  logic               btn_clear;
  logic [7:0]         rx_data;
  logic               rx_done;
  logic               load_en;
  logic [COUNT_W-1:0] load_val;
  logic [COUNT_W-1:0] count;
  logic               tc;
  logic               running;
  logic [1:0]         led_mode;
  logic [1:0]         led_run_stop;

  // Driver side: buttons, UART and preset in; count/status back.
  modport master (
    output btn_mode, btn_run_stop, btn_clear, rx_data, rx_done, load_en, load_val,
    input  count, tc, running, led_mode, led_run_stop
  );

  // Counter side.
  modport slave (
    input  btn_mode, btn_run_stop, btn_clear, rx_data, rx_done, load_en, load_val,
    output count, tc, running, led_mode, led_run_stop
  );
endinterface

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with mode/run FSMs and a tick divider.
// Optional feature: define UDC_ONESHOT_EN to stop the run FSM on every count wrap.
module updown_counter_gen #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = 9999,
  parameter int COUNT_W   = 14
) (
  input  logic           clk,
  input  logic           reset,
  updown_counter_gen_if.slave bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_COUNT);

  // Parameter sanity, reported at elaboration.
  if (CLK_HZ % TICK_HZ != 0) begin : g_bad_ratio
    $error("updown_counter_gen: CLK_HZ must be a multiple of TICK_HZ");
  end
  if (DIV < 2) begin : g_bad_div
    $error("updown_counter_gen: CLK_HZ/TICK_HZ must be at least 2");
  end
  if ((longint'(1) << COUNT_W) <= longint'(MAX_COUNT)) begin : g_bad_width
    $error("updown_counter_gen: COUNT_W too narrow for MAX_COUNT");
  end

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    RUN_STOP  = 2'd0,
    RUN_RUN   = 2'd1,
    RUN_CLEAR = 2'd2
  } run_state_e;

  mode_e              mode_q, mode_d;
  run_state_e         run_q, run_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tc_q, tc_d;

  logic cmd_mode, cmd_run, cmd_stop, cmd_clear;
  logic mode_req, clear_req, run_req, stop_req;
  logic clear_int;
  logic tick;
  logic wrap_evt;

  // ---------------------------------------------------------------------
  // UART command decode: only bytes qualified by rx_done are commands.
  // ---------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd_mode  = 1'b0;
    cmd_run   = 1'b0;
    cmd_stop  = 1'b0;
    cmd_clear = 1'b0;
    if (bus.rx_done) begin
      case (bus.rx_data)
        8'h4D, 8'h6D: cmd_mode  = 1'b1;
        8'h52, 8'h72: cmd_run   = 1'b1;
        8'h53, 8'h73: cmd_stop  = 1'b1;
        8'h43, 8'h63: cmd_clear = 1'b1;
        default: ;
      endcase
    end
  end

  assign mode_req  = bus.btn_mode  | cmd_mode;
  assign clear_req = bus.btn_clear | cmd_clear;
  assign run_req   = bus.btn_run_stop | cmd_run;
  assign stop_req  = bus.btn_run_stop | cmd_stop;

  // Simultaneous button and command still toggle only once.
  always_comb begin
    mode_d = mode_q;
    if (mode_req) begin
      mode_d = (mode_q == MODE_UP) ? MODE_DOWN : MODE_UP;
    end
  end

  // ---------------------------------------------------------------------
  // Run FSM: next-state logic. Clear always outranks run/stop.
  // ---------------------------------------------------------------------
  always_comb begin
    run_d = run_q;
    case (run_q)
      RUN_STOP: begin
        if (clear_req)    run_d = RUN_CLEAR;
        else if (run_req) run_d = RUN_RUN;
      end
      RUN_RUN: begin
        if (clear_req)     run_d = RUN_CLEAR;
        else if (stop_req) run_d = RUN_STOP;
`ifdef UDC_ONESHOT_EN
        else if (wrap_evt) run_d = RUN_STOP;
`endif
      end
      RUN_CLEAR: run_d = RUN_STOP;
      default:   run_d = RUN_STOP;
    endcase
  end

  // Run FSM / mode outputs, decoded from the registered states only.
  always_comb begin
    bus.running      = 1'b0;
    bus.led_run_stop = 2'b01;
    clear_int        = 1'b0;
    case (run_q)
      RUN_RUN: begin
        bus.running      = 1'b1;
        bus.led_run_stop = 2'b10;
      end
      RUN_CLEAR: begin
        bus.led_run_stop = 2'b00;
        clear_int        = 1'b1;
      end
      default: ;
    endcase
    bus.led_mode = (mode_q == MODE_UP) ? 2'b01 : 2'b10;
  end

  // ---------------------------------------------------------------------
  // Tick divider: advances only in RUN and holds in STOP to keep phase.
  // ---------------------------------------------------------------------
  assign tick = (run_q == RUN_RUN) && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (clear_int || bus.load_en) begin
      div_d = '0;
    end else if (run_q == RUN_RUN) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Count datapath, priority clear > load > tick. tc flags a wrap only.
  // ---------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    wrap_evt = 1'b0;
    if (clear_int) begin
      count_d = '0;
    end else if (bus.load_en) begin
      count_d = (bus.load_val > COUNT_MAX) ? COUNT_MAX : bus.load_val;
    end else if (tick) begin
      if (mode_q == MODE_UP) begin
        if (count_q == COUNT_MAX) begin
          count_d  = '0;
          wrap_evt = 1'b1;
        end else begin
          count_d = count_q + COUNT_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d  = COUNT_MAX;
          wrap_evt = 1'b1;
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end
    end
    tc_d = wrap_evt;
  end

  // ---------------------------------------------------------------------
  // State registers, synchronous reset.
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_UP;
      run_q   <= RUN_STOP;
      div_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      run_q   <= run_d;
      div_q   <= div_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench for updown_counter_gen: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a cycle model.
module tb_updown_counter_gen;

  localparam int DIV  = 10;
  localparam int MAXC = 15;
  localparam int ST_STOP  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_CLEAR = 2;

`ifdef UDC_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  updown_counter_gen_if #(.COUNT_W(4)) bus ();
  updown_counter_gen_if #(.COUNT_W(5)) bus5 ();

  updown_counter_gen #(
    .CLK_HZ(100), .TICK_HZ(10), .MAX_COUNT(15), .COUNT_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  updown_counter_gen #(
    .CLK_HZ(100), .TICK_HZ(10), .MAX_COUNT(15), .COUNT_W(5)
  ) u_dut5 (
    .clk(clk), .reset(reset), .bus(bus5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: count value, wrap flag, cycles spent running since
  // the phase was last zeroed, direction and run state.
  int m_count;
  int m_tc;
  int m_elapsed;
  bit m_up;
  int m_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_byte(logic [7:0] d, logic [7:0] a, logic [7:0] b);
    return (d == a) || (d == b);
  endfunction

  // Model: advances on every rising edge from the inputs the DUT also sees.
  initial begin
    bit clr, run_t, stop_t, mode_t, tick, wrap, was_running;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_count = 0; m_tc = 0; m_elapsed = 0; m_up = 1'b1; m_state = ST_STOP;
      end else begin
        clr    = bus.btn_clear    || (bus.rx_done && is_byte(bus.rx_data, "C", "c"));
        run_t  = bus.btn_run_stop || (bus.rx_done && is_byte(bus.rx_data, "R", "r"));
        stop_t = bus.btn_run_stop || (bus.rx_done && is_byte(bus.rx_data, "S", "s"));
        mode_t = bus.btn_mode     || (bus.rx_done && is_byte(bus.rx_data, "M", "m"));
        was_running = (m_state == ST_RUN);
        tick = was_running && ((m_elapsed % DIV) == DIV - 1);
        wrap = 1'b0;
        m_tc = 0;
        if (m_state == ST_CLEAR) begin
          m_count = 0; m_elapsed = 0;
        end else if (bus.load_en) begin
          m_count = (int'(bus.load_val) > MAXC) ? MAXC : int'(bus.load_val);
          m_elapsed = 0;
        end else begin
          if (tick) begin
            if (m_up) begin
              wrap = (m_count == MAXC);
              m_count = (m_count + 1) % (MAXC + 1);
            end else begin
              wrap = (m_count == 0);
              m_count = (m_count + MAXC) % (MAXC + 1);
            end
            m_tc = wrap ? 1 : 0;
          end
          if (was_running) m_elapsed++;
        end
        if (mode_t) m_up = !m_up;
        case (m_state)
          ST_STOP: m_state = clr ? ST_CLEAR : (run_t ? ST_RUN : ST_STOP);
          ST_RUN:  m_state = clr ? ST_CLEAR :
                             ((stop_t || (ONESHOT && wrap)) ? ST_STOP : ST_RUN);
          default: m_state = ST_STOP;
        endcase
      end
    end
  end

  // Compare process: every falling edge once the model is in step.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model_count", 32'(bus.count), m_count);
        check("model_tc", 32'(bus.tc), m_tc);
        check("model_running", 32'(bus.running), (m_state == ST_RUN) ? 1 : 0);
        check("model_led_mode", 32'(bus.led_mode), m_up ? 1 : 2);
        check("model_led_run_stop", 32'(bus.led_run_stop),
              (m_state == ST_RUN) ? 2 : ((m_state == ST_CLEAR) ? 0 : 1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // All drivers start and end on a falling edge.
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_n(2);
    reset = 1'b0;
  endtask

  task automatic pulse_run();
    bus.btn_run_stop = 1'b1;
    wait_n(1);
    bus.btn_run_stop = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    wait_n(1);
    bus.rx_done = 1'b0;
  endtask

  task automatic load(input logic [3:0] v);
    bus.load_en  = 1'b1;
    bus.load_val = v;
    wait_n(1);
    bus.load_en  = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 8))
      0: return "M";
      1: return "m";
      2: return "R";
      3: return "r";
      4: return "S";
      5: return "s";
      6: return "C";
      7: return "c";
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int tc_cnt;
    bus.btn_mode = 0; bus.btn_run_stop = 0; bus.btn_clear = 0;
    bus.rx_data = 0; bus.rx_done = 0; bus.load_en = 0; bus.load_val = 0;
    bus5.btn_mode = 0; bus5.btn_run_stop = 0; bus5.btn_clear = 0;
    bus5.rx_data = 0; bus5.rx_done = 0; bus5.load_en = 0; bus5.load_val = 0;
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;

    // Reset state.
    check("rst_count", 32'(bus.count), 0);
    check("rst_tc", 32'(bus.tc), 0);
    check("rst_running", 32'(bus.running), 0);
    check("rst_led_mode", 32'(bus.led_mode), 1);
    check("rst_led_run_stop", 32'(bus.led_run_stop), 1);

    // Count up from RUN entry, through the 15 -> 0 wrap.
    pulse_run();
    check("t1_running", 32'(bus.running), 1);
    wait_n(9);
    check("t1_before_tick", 32'(bus.count), 0);
    wait_n(1);
    check("t1_first_tick", 32'(bus.count), 1);
    tc_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      wait_n(1);
      if (bus.tc === 1'b1) tc_cnt++;
    end
    check("t1_wrap_count", 32'(bus.count), 0);
    check("t1_wrap_tc", 32'(bus.tc), 1);
    check("t1_tc_pulses", tc_cnt, 1);
    wait_n(1);
    check("t1_tc_drop", 32'(bus.tc), 0);

    // Down mode via UART: 0 -> 15 with tc, then 14.
    do_reset();
    send_rx("m");
    send_rx("R");
    check("t2_led_mode", 32'(bus.led_mode), 2);
    check("t2_running", 32'(bus.running), 1);
    wait_n(10);
    check("t2_wrap_count", 32'(bus.count), 15);
    check("t2_wrap_tc", 32'(bus.tc), 1);
    wait_n(10);
    check("t2_next_count", 32'(bus.count), ONESHOT ? 15 : 14);
    check("t2_next_tc", 32'(bus.tc), 0);

    // Stop mid-phase and resume: phase is kept across STOP.
    do_reset();
    pulse_run();
    wait_n(70);
    check("t3_count7", 32'(bus.count), 7);
    wait_n(3);
    pulse_run();
    check("t3_stopped", 32'(bus.running), 0);
    wait_n(50);
    check("t3_hold", 32'(bus.count), 7);
    send_rx("r");
    check("t3_resumed", 32'(bus.running), 1);
    wait_n(5);
    check("t3_pre8", 32'(bus.count), 7);
    wait_n(1);
    check("t3_count8", 32'(bus.count), 8);

    // Load colliding with a tick; clamp on the wider instance.
    do_reset();
    pulse_run();
    wait_n(9);
    bus.load_en = 1'b1; bus.load_val = 4'd12;
    bus5.load_en = 1'b1; bus5.load_val = 5'd20;
    wait_n(1);
    bus.load_en = 1'b0; bus5.load_en = 1'b0;
    check("t4_load", 32'(bus.count), 12);
    check("t4_load_tc", 32'(bus.tc), 0);
    check("t4_clamp", 32'(bus5.count), 15);
    wait_n(9);
    check("t4_restart_hold", 32'(bus.count), 12);
    wait_n(1);
    check("t4_restart_tick", 32'(bus.count), 13);
    bus5.load_en = 1'b1; bus5.load_val = 5'd9;
    wait_n(1);
    bus5.load_en = 1'b0;
    check("t4_load5_in_range", 32'(bus5.count), 9);

    // Clear and run together in STOP; 'C' during RUN.
    do_reset();
    load(4'd5);
    check("t5_load_stop", 32'(bus.count), 5);
    bus.btn_clear = 1'b1; bus.btn_run_stop = 1'b1;
    wait_n(1);
    bus.btn_clear = 1'b0; bus.btn_run_stop = 1'b0;
    check("t5_clear_led", 32'(bus.led_run_stop), 0);
    check("t5_clear_running", 32'(bus.running), 0);
    wait_n(1);
    check("t5_after_clear_led", 32'(bus.led_run_stop), 1);
    check("t5_after_clear_count", 32'(bus.count), 0);
    pulse_run();
    wait_n(25);
    check("t5_run_count", 32'(bus.count), 2);
    send_rx("C");
    check("t5_c_led", 32'(bus.led_run_stop), 0);
    wait_n(1);
    check("t5_c_count", 32'(bus.count), 0);
    check("t5_c_running", 32'(bus.running), 0);

    // Wrap from 14 upward: stops there only in the one-shot build.
    do_reset();
    load(4'd14);
    pulse_run();
    wait_n(10);
    check("t6_count15", 32'(bus.count), 15);
    wait_n(10);
    check("t6_wrap", 32'(bus.count), 0);
    check("t6_tc", 32'(bus.tc), 1);
    check("t6_running", 32'(bus.running), ONESHOT ? 0 : 1);
    wait_n(100);
    check("t6_after", 32'(bus.count), ONESHOT ? 0 : 10);

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset            = ($urandom_range(0, 499) == 0);
      bus.btn_mode     = ($urandom_range(0, 39) == 0);
      bus.btn_run_stop = ($urandom_range(0, 19) == 0);
      bus.btn_clear    = ($urandom_range(0, 149) == 0);
      bus.rx_done      = ($urandom_range(0, 14) == 0);
      bus.rx_data      = pick_byte();
      bus.load_en      = ($urandom_range(0, 99) == 0);
      bus.load_val     = 4'($urandom_range(0, 15));
      wait_n(1);
    end
    reset = 1'b0;
    bus.btn_mode = 0; bus.btn_run_stop = 0; bus.btn_clear = 0;
    bus.rx_done = 0; bus.load_en = 0;
    wait_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
- Parametrised up/down counter with an integrated control FSM and tick generator. It is the next generation of the 10 Hz stopwatch-style counter.
- Adds configurable clock/tick rates, a configurable modulus, preset load, a terminal-count pulse, and deterministic priority for clear/load/tick.
- Sits between debounced buttons plus UART RX and the FND display driver. It accepts the same button and ASCII command set as the previous counter.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 10, count rate. DIV = CLK_HZ/TICK_HZ. Requires CLK_HZ % TICK_HZ == 0 and DIV >= 2.
- MAX_COUNT, 9999, counter modulus minus 1. Count range is 0..MAX_COUNT.
- COUNT_W, 14, count width. Requires 2**COUNT_W > MAX_COUNT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  single-cycle pulse: toggle up/down
- btn_run_stop  in  1  single-cycle pulse: run/stop toggle
- btn_clear  in  1  single-cycle pulse: clear request
- rx_data  in  8  UART byte
- rx_done  in  1  single-cycle strobe: rx_data valid
- load_en  in  1  single-cycle pulse: preset count
- load_val  in  COUNT_W  preset value
- count  out  COUNT_W  current count, registered
- tc  out  1  terminal-count pulse, registered
- running  out  1  high while in RUN
- led_mode  out  2  01 = UP, 10 = DOWN
- led_run_stop  out  2  01 = STOP, 10 = RUN, 00 = CLEAR

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state changes happen on posedge clk only.
- Reset values: count=0, tc=0, div counter=0, mode FSM=UP, run FSM=STOP. Therefore led_mode=01, led_run_stop=01, running=0.
- Command decode: a command is valid only when rx_done=1.
  - 'M'/'m' (0x4D/0x6D) = mode.
  - 'R'/'r' (0x52/0x72) = run.
  - 'S'/'s' (0x53/0x73) = stop.
  - 'C'/'c' (0x43/0x63) = clear.
  - All other bytes are ignored.
- Mode FSM (UP/DOWN):
  - btn_mode or a mode command toggles the state.
  - Both in the same cycle produce one toggle only.
  - Visible one cycle after the request.
- Run FSM (STOP/RUN/CLEAR):
  - STOP: a clear request (btn_clear or 'C') -> CLEAR. Otherwise btn_run_stop or 'R' -> RUN. Clear has priority. 'S' is ignored.
  - RUN: a clear request -> CLEAR. Otherwise btn_run_stop or 'S' -> STOP. 'R' is ignored. Clear-from-RUN is new behaviour.
  - CLEAR: lasts exactly one cycle, asserts the internal clear, then -> STOP unconditionally.
- Tick generator:
  - Div counter 0..DIV-1, advances only in RUN.
  - A one-cycle tick fires when the counter is at DIV-1; the counter then wraps to 0.
  - In STOP the counter holds its value, so a resume keeps the phase.
  - Zeroed by CLEAR and by load_en.
  - First tick after leaving CLEAR comes DIV cycles after RUN is entered.
- Counter update priority: reset > clear > load_en > tick.
  - Clear: count=0; tc is not asserted.
  - Load: count = min(load_val, MAX_COUNT); tc is not asserted. Load is honoured in any run state.
  - Tick, UP: count==MAX_COUNT -> 0 with tc=1; else count+1.
  - Tick, DOWN: count==0 -> MAX_COUNT with tc=1; else count-1.
  - Mode is sampled in the same cycle as the tick, so a mode change takes effect on the first tick after the state register updates.
  - tc is high for exactly the one cycle in which the wrapped count is presented; 0 otherwise.
- Latency: tick at cycle N -> new count (and tc) visible at N+1.
- Reset asserted mid-run: all state returns to reset values on the next edge, regardless of other inputs.

Optional Feature:
- UDC_ONESHOT_EN defined: a wrap event still updates count and pulses tc, and in the same cycle forces the run FSM RUN -> STOP. Any clear request in that cycle still wins (-> CLEAR). The counter stops on the wrapped value.
- UDC_ONESHOT_EN undefined: the counter wraps and keeps running.

Test Plan (CLK_HZ=100, TICK_HZ=10, so DIV=10; MAX_COUNT=15; COUNT_W=4):
- Reset, then btn_run_stop pulse -> running=1; count=1 exactly 10 cycles after RUN entry. After 160 cycles count=0 and a single-cycle tc pulse has occurred.
- Down mode: rx 'm' then 'R' -> count goes 0 -> 15 on the first tick with tc=1, then 14 on the next tick.
- In RUN at count=7, btn_run_stop after 4 div cycles, wait 50 cycles, then 'r' -> count stays 7 during STOP; it reaches 8 six cycles after resume.
- load_en with load_val=12 while a tick arrives in the same cycle -> count=12 and the div counter restarts. load_val=20 is impossible at COUNT_W=4, so rerun with COUNT_W=5 and load_val=20 -> count=15.
- btn_clear and btn_run_stop together in STOP -> CLEAR for one cycle (led_run_stop=00), then STOP, count=0. 'C' during RUN -> count=0 and state STOP.
- UDC_ONESHOT_EN, UP mode from 14 -> after two ticks count=0, tc pulse, running=0, and count stays 0 for a further 100 cycles.
